// File: rtl/magic_buttons_pkg.sv
// Shared types and helpers for the MAGIC button front-end.
package magic_buttons_pkg;

  localparam int FRAME_CNT_W = 6;

  typedef enum logic [2:0] {
    BS_ARM    = 3'd0,
    BS_IDLE   = 3'd1,
    BS_PRESS1 = 3'd2,
    BS_WAIT2  = 3'd3,
    BS_PRESS2 = 3'd4,
    BS_LONG   = 3'd5
  } btn_state_t;

  function automatic logic [FRAME_CNT_W-1:0] frame_cnt_inc(input logic [FRAME_CNT_W-1:0] cnt);
    if (cnt == {FRAME_CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/magic_buttons_if.sv
// Button/hotkey inputs and classified request outputs of the MAGIC front-end.
interface magic_buttons_if;
  logic button_n;
  logic kbd_magic;
  logic kbd_pause;
  logic kbd_ff;
  logic magic_button;
  logic pause_button;
  logic fastforward_button;

  modport master (
    output button_n, kbd_magic, kbd_pause, kbd_ff,
    input  magic_button, pause_button, fastforward_button
  );

  modport slave (
    input  button_n, kbd_magic, kbd_pause, kbd_ff,
    output magic_button, pause_button, fastforward_button
  );
endinterface

// File: rtl/magic_buttons_debounce.sv
// Synchroniser plus ck35-timed debouncer for one active-low push button.
module magic_buttons_debounce #(
  parameter int TICKS = 17500
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic ck35,
  input  logic raw,
  output logic level,
  output logic stable
);

  localparam logic [14:0] TICK_LAST = 15'(TICKS - 1);

  logic [1:0]  sync_r;
  logic [1:0]  ready_r;
  logic [14:0] cnt_r;
  logic        level_r;

  // Two-flop synchroniser; ready_r marks when the pipe holds real samples.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= 2'b11;
      ready_r <= 2'b00;
    end else begin
      sync_r  <= {sync_r[0], raw};
      ready_r <= {ready_r[0], 1'b1};
    end
  end

  // Accept a new level only after it has disagreed for TICKS ck35 ticks in a row.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 15'd0;
      level_r <= 1'b1;
    end else if (sync_r[1] == level_r) begin
      cnt_r <= 15'd0;
    end else if (ck35) begin
      if (cnt_r == TICK_LAST) begin
        level_r <= sync_r[1];
        cnt_r   <= 15'd0;
      end else begin
        cnt_r <= cnt_r + 15'd1;
      end
    end
  end

  assign level  = level_r;
  assign stable = ready_r[1] && (sync_r[1] == level_r);

endmodule

// File: rtl/magic_buttons.sv
// MAGIC button classifier: short -> magic, double short -> pause, long hold -> fast-forward.
module magic_buttons
  import magic_buttons_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 17500,
  parameter int LONG_FRAMES    = 25,
  parameter int DOUBLE_FRAMES  = 15
) (
  input  logic           clk28,
  input  logic           rst_n,
  input  logic           ck35,
  input  logic           n_int,
  input  logic           n_int_next,
  magic_buttons_if.slave btn
);

  localparam logic [FRAME_CNT_W-1:0] LONG_CNT   = FRAME_CNT_W'(LONG_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] DOUBLE_CNT = FRAME_CNT_W'(DOUBLE_FRAMES);

  btn_state_t             state_r;
  btn_state_t             state_s;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic                   level_s;
  logic                   stable_s;
  logic                   pressed_s;
  logic                   frame_edge_s;
  logic                   timing_s;
  logic                   magic_ev_s;
  logic                   pause_ev_s;
  logic                   magic_r;
  logic                   pause_r;
  logic                   ff_r;

  magic_buttons_debounce #(.TICKS(DEBOUNCE_TICKS)) u_debounce (
    .clk28  (clk28),
    .rst_n  (rst_n),
    .ck35   (ck35),
    .raw    (btn.button_n),
    .level  (level_s),
    .stable (stable_s)
  );

  assign pressed_s    = ~level_s;
  assign frame_edge_s = n_int & ~n_int_next;
  assign timing_s     = state_r inside {BS_PRESS1, BS_WAIT2, BS_PRESS2};

  // State register.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BS_ARM;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and one-cycle request events.
  always_comb begin
    state_s    = state_r;
    magic_ev_s = 1'b0;
    pause_ev_s = 1'b0;
    case (state_r)
      BS_ARM: begin
        // only trust "released" once the synchroniser holds real samples
        if (stable_s && !pressed_s) state_s = BS_IDLE;
        else                        state_s = BS_ARM;
      end
      BS_IDLE: begin
        if (pressed_s) state_s = BS_PRESS1;
        else           state_s = BS_IDLE;
      end
      BS_PRESS1: begin
        if (frame_cnt_r == LONG_CNT) state_s = BS_LONG;
        else if (!pressed_s)         state_s = BS_WAIT2;
        else                         state_s = BS_PRESS1;
      end
      BS_WAIT2: begin
        if (pressed_s) begin
          state_s = BS_PRESS2;
        end else if (frame_cnt_r == DOUBLE_CNT) begin
          state_s    = BS_IDLE;
          magic_ev_s = 1'b1;
        end else begin
          state_s = BS_WAIT2;
        end
      end
      BS_PRESS2: begin
        if (!pressed_s) begin
          state_s    = BS_IDLE;
          pause_ev_s = 1'b1;
        end else if (frame_cnt_r == LONG_CNT) begin
          state_s    = BS_LONG;
          pause_ev_s = 1'b1;
        end else begin
          state_s = BS_PRESS2;
        end
      end
      BS_LONG: begin
        if (!pressed_s) state_s = BS_IDLE;
        else            state_s = BS_LONG;
      end
      default: state_s = BS_ARM;
    endcase
  end

  // Frame counter: restarts on every state change, advances on frame edges in timing states.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= {FRAME_CNT_W{1'b0}};
    end else if (state_s != state_r) begin
      frame_cnt_r <= {FRAME_CNT_W{1'b0}};
    end else if (frame_edge_s && timing_s) begin
      frame_cnt_r <= frame_cnt_inc(frame_cnt_r);
    end
  end

  // Request latches: set wins over the frame-edge clear, so a re-trigger is never lost.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      magic_r <= 1'b0;
      pause_r <= 1'b0;
      ff_r    <= 1'b0;
    end else begin
      magic_r <= magic_ev_s | btn.kbd_magic | (magic_r & ~frame_edge_s);
      pause_r <= pause_ev_s | btn.kbd_pause | (pause_r & ~frame_edge_s);
      ff_r    <= ((state_r == BS_LONG) && pressed_s) | btn.kbd_ff;
    end
  end

  assign btn.magic_button       = magic_r;
  assign btn.pause_button       = pause_r;
  assign btn.fastforward_button = ff_r;

endmodule
